// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: E0/F0 prefix FSM, modifier tracking, FWFT event FIFO.
// Optional ASCII translation is enabled by defining ASCII_XLAT_EN.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic [3:0] mods,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef ASCII_XLAT_EN
  localparam int unsigned EW = 18;
`else
  localparam int unsigned EW = 10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           overflow_q, overflow_d;
  logic           lshift_q, lshift_d, rshift_q, rshift_d;
  logic           ctrl_q, ctrl_d, alt_q, alt_d;
  logic           caps_held_q, caps_held_d, caps_lock_q, caps_lock_d;

  logic           emit, e_ext, e_brk, dropped_byte;
  logic           pop, full, push_ok, drop;
  logic [EW-1:0]  wr_data, head;
  logic           shift_now;

  assign dropped_byte = (scan_code == 8'h00) || (scan_code == 8'hAA) || (scan_code == 8'hEE) ||
                        (scan_code == 8'hFA) || (scan_code == 8'hFE) || (scan_code == 8'hFF);

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    e_ext   = 1'b0;
    e_brk   = 1'b0;
    if (scan_valid) begin
      case (state_q)
        S_IDLE: begin
          if (scan_code == 8'hE0)      state_d = S_EXT;
          else if (scan_code == 8'hF0) state_d = S_BRK;
          else if (!dropped_byte)      emit = 1'b1;
        end
        S_EXT: begin
          if (scan_code == 8'hF0)      state_d = S_EXT_BRK;
          else if (scan_code != 8'hE0) begin
            emit    = 1'b1;
            e_ext   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          emit    = 1'b1;
          e_brk   = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          emit    = 1'b1;
          e_ext   = 1'b1;
          e_brk   = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
    // A received byte always restarts the prefix timer, even if it lands on the expiry cycle.
    if (scan_valid || state_q == S_IDLE) begin
      tcnt_d = '0;
    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tcnt_d  = '0;
      state_d = S_IDLE;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  assign shift_now = lshift_q | rshift_q;

`ifdef ASCII_XLAT_EN
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic upper);
    logic [7:0] a;
    logic       letter;
    a      = 8'h00;
    letter = 1'b1;
    case (c)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      default: begin
        letter = 1'b0;
        case (c)
          8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
          8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
          8'h3E: a = 8'h38;  8'h46: a = 8'h39;  8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
          8'h66: a = 8'h08;
          default: a = 8'h00;
        endcase
      end
    endcase
    if (letter && upper) a = a - 8'h20;
    return a;
  endfunction

  always_comb begin
    wr_data = {8'h00, e_brk, e_ext, scan_code};
    if (!e_brk && !e_ext) wr_data[17:10] = to_ascii(scan_code, shift_now ^ caps_lock_q);
  end
`else
  assign wr_data = {e_brk, e_ext, scan_code};
`endif

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    ctrl_d      = ctrl_q;
    alt_d       = alt_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    if (emit) begin
      case (scan_code)
        8'h12: if (!e_ext) lshift_d = ~e_brk;
        8'h59: if (!e_ext) rshift_d = ~e_brk;
        8'h14: ctrl_d = ~e_brk;
        8'h11: alt_d  = ~e_brk;
        8'h58: begin
          if (e_brk) begin
            caps_held_d = 1'b0;
          end else if (!caps_held_q) begin
            caps_held_d = 1'b1;
            caps_lock_d = ~caps_lock_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = (cnt_q != '0) && ev_ready;
  assign push_ok = emit && (!full || pop);
  assign drop    = emit && full && !pop;

  always_comb begin
    wptr_d     = wptr_q + AW'(push_ok);
    rptr_d     = rptr_q + AW'(pop);
    cnt_d      = cnt_q + CW'(push_ok) - CW'(pop);
    overflow_d = (overflow_q && !ovf_clr) || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
      if (push_ok) mem_q[wptr_q] <= wr_data;
    end
  end

  assign head     = mem_q[rptr_q];
  assign ev_valid = (cnt_q != '0);
  assign ev_code  = ev_valid ? head[7:0] : 8'h00;
  assign ev_ext   = ev_valid & head[8];
  assign ev_break = ev_valid & head[9];
`ifdef ASCII_XLAT_EN
  assign ev_ascii = ev_valid ? head[17:10] : 8'h00;
`else
  assign ev_ascii = 8'h00;
`endif
  assign mods     = {caps_lock_q, alt_q, ctrl_q, shift_now};
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (TIMEOUT_CYCLES=16, FIFO_DEPTH=4).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code, ev_ascii;
  logic [3:0] mods;

  int n_chk = 0;
  int n_pass = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_ascii(ev_ascii), .mods(mods), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_chk, n_pass);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ax(input logic [7:0] x);
`ifdef ASCII_XLAT_EN
    return x;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pop_ev(input string tag, input logic [7:0] c, input logic x,
                        input logic br, input logic [7:0] a);
    check(tag, {15'd0, ev_valid, ev_ext, ev_break, ev_code, ev_ascii}, {15'd0, 1'b1, x, br, c, a});
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {ev_valid, ev_ext, ev_break, ev_code, ev_ascii, mods, overflow},
          {3'b000, 8'h00, 8'h00, 4'h0, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // make then break of 'a'
    send(8'h1C);
    check("make_latency", {31'd0, ev_valid}, 32'd1);
    pop_ev("make_1C", 8'h1C, 1'b0, 1'b0, ax(8'h61));
    send(8'hF0);
    check("prefix_no_event", {31'd0, ev_valid}, 32'd0);
    send(8'h1C);
    pop_ev("break_1C", 8'h1C, 1'b0, 1'b1, 8'h00);

    // extended make/break
    send(8'hE0); send(8'h75);
    pop_ev("ext_make_75", 8'h75, 1'b1, 1'b0, 8'h00);
    send(8'hE0); send(8'hF0); send(8'h75);
    pop_ev("ext_break_75", 8'h75, 1'b1, 1'b1, 8'h00);
    check("mods_after_ext", {28'd0, mods}, 32'h0);

    // shift and caps lock
    send(8'h12);
    pop_ev("make_lshift", 8'h12, 1'b0, 1'b0, 8'h00);
    check("mods_shift", {28'd0, mods}, 32'h1);
    send(8'h1C);
    pop_ev("shifted_a", 8'h1C, 1'b0, 1'b0, ax(8'h41));
    send(8'hF0); send(8'h12);
    pop_ev("break_lshift", 8'h12, 1'b0, 1'b1, 8'h00);
    send(8'h1C);
    pop_ev("plain_a", 8'h1C, 1'b0, 1'b0, ax(8'h61));
    send(8'h58);
    pop_ev("caps_make", 8'h58, 1'b0, 1'b0, 8'h00);
    check("caps_on", {28'd0, mods}, 32'h8);
    send(8'h58);
    pop_ev("caps_repeat", 8'h58, 1'b0, 1'b0, 8'h00);
    check("caps_repeat_ignored", {28'd0, mods}, 32'h8);
    send(8'hF0); send(8'h58);
    pop_ev("caps_break", 8'h58, 1'b0, 1'b1, 8'h00);
    check("caps_after_break", {28'd0, mods}, 32'h8);
    send(8'h1C);
    pop_ev("caps_a", 8'h1C, 1'b0, 1'b0, ax(8'h41));

    // FIFO fill and overflow
    for (int i = 0; i < 4; i++) send(8'h16);
    check("full_no_ovf", {31'd0, overflow}, 32'd0);
    send(8'h16);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) pop_ev("drain_16", 8'h16, 1'b0, 1'b0, ax(8'h31));
    check("drained_empty", {31'd0, ev_valid}, 32'd0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // push and pop together while full
    for (int i = 0; i < 4; i++) send(8'h16);
    ev_ready = 1'b1;
    send(8'h1C);
    ev_ready = 1'b0;
    check("full_push_pop_no_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) pop_ev("fp_16", 8'h16, 1'b0, 1'b0, ax(8'h31));
    pop_ev("fp_1C", 8'h1C, 1'b0, 1'b0, ax(8'h41));
    check("fp_empty", {31'd0, ev_valid}, 32'd0);

    // timeout
    send(8'hE0);
    repeat (5) @(negedge clk);
    send(8'h75);
    pop_ev("before_timeout_ext", 8'h75, 1'b1, 1'b0, 8'h00);
    send(8'hE0);
    repeat (20) @(negedge clk);
    send(8'h1C);
    pop_ev("after_timeout_plain", 8'h1C, 1'b0, 1'b0, ax(8'h41));
    send(8'hAA); send(8'hFA);
    check("dropped_bytes", {31'd0, ev_valid}, 32'd0);

    // reset mid-sequence
    send(8'h16); send(8'h16); send(8'hF0);
    check("queued_two", {31'd0, ev_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {27'd0, ev_valid, mods}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h1C);
    pop_ev("post_reset_make", 8'h1C, 1'b0, 1'b0, ax(8'h61));
    check("post_reset_empty", {31'd0, ev_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Consumes the raw byte stream from the PS/2 receiver stage (8-bit byte plus one-cycle done pulse) and turns Set-2 scan-code sequences into key events. Handles E0 (extended) and F0 (break) prefixes, tracks modifier state, optionally translates to ASCII, and buffers events in a small first-word-fall-through FIFO for the downstream consumer.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 500000, clk cycles a partial prefix sequence may wait for its next byte before being discarded.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
scan_code  in  8  byte from PS/2 receiver, valid when scan_valid=1.
scan_valid  in  1  one-cycle pulse marking a new byte.
ev_valid  out  1  FIFO non-empty; head event on ev_* outputs.
ev_ready  in  1  consumer pops head when ev_valid&ev_ready at a rising edge.
ev_code  out  8  key code, prefixes stripped.
ev_ext  out  1  event came from an E0 sequence.
ev_break  out  1  1=key release, 0=key press.
ev_ascii  out  8  ASCII of event (0x00 if none).
mods  out  4  {caps_lock, alt, ctrl, shift}, live state.
overflow  out  1  sticky: an event was dropped because the FIFO was full.
ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, timeout counter=0, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_ascii=0, mods=0, overflow=0, all internal held-key flags=0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions only on scan_valid:
  IDLE: E0->EXT; F0->BRK; 00/AA/EE/FA/FE/FF dropped, stay IDLE; any other byte -> emit make, stay IDLE.
  EXT: F0->EXT_BRK; E0 -> stay EXT; other -> emit extended make, ->IDLE.
  BRK: any byte -> emit break, ->IDLE.
  EXT_BRK: any byte -> emit extended break, ->IDLE.
- Timeout: counter clears on every scan_valid and in IDLE; counts in other states; reaching TIMEOUT_CYCLES-1 returns FSM to IDLE with no event.
- Emit: event written to FIFO at the same rising edge scan_valid is sampled; ev_valid high from the following cycle (1-cycle latency when FIFO empty). ev_* reflect the FIFO head only (first-word-fall-through).
- FIFO: push when full and no simultaneous pop -> event dropped, overflow set. Push and pop in the same cycle when full: both succeed. Pop when empty ignored. Pointers wrap modulo FIFO_DEPTH. ovf_clr and a new overflow in the same cycle: overflow stays 1.
- Modifiers (update at emit, regardless of FIFO full): shift = left(12, non-ext) OR right(59, non-ext) held; ctrl = 14 held (ext or not); alt = 11 held (ext or not). caps_lock toggles on make of 58 only if 58 not already held (typematic repeats ignored); cleared hold flag on 58 break.
- A break for a key not held still emits an event.
- Reset mid-sequence discards the partial prefix and all FIFO contents.

Optional Feature:
ASCII_XLAT_EN: defined -> ev_ascii from table, computed with mods before this event's update: letters 1C=a 32=b 21=c 23=d 24=e 2B=f 34=g 33=h 43=i 3B=j 42=k 4B=l 3A=m 31=n 44=o 4D=p 15=q 2D=r 1B=s 2C=t 3C=u 2A=v 1D=w 22=x 35=y 1A=z, uppercase when shift XOR caps_lock; digits 45=0 16=1 1E=2 26=3 25=4 2E=5 36=6 3D=7 3E=8 46=9 (shift ignored); 29=0x20, 5A=0x0D, 66=0x08. Break, extended and unmapped events give 0x00. Not defined -> ev_ascii constant 0x00, no table logic; FIFO width drops the ASCII field.

Test Plan:
Reset, bytes 1C then F0 1C, ev_ready=1 -> events {code=1C,ext=0,brk=0,ascii=0x61} then {1C,0,1,0x00}; ev_valid high 1 cycle after each final scan_valid.
E0 75, then E0 F0 75 -> {75,ext=1,brk=0,ascii=0} then {75,1,1,0}; mods unchanged.
12, 1C, F0 12, 1C; then 58, 58, F0 58, 1C -> ascii 0x41, 0x61; caps_lock=1 after first 58 only; last event ascii 0x41.
ev_ready=0, push FIFO_DEPTH+1 makes of 16 -> 4 events held, overflow=1; pop all -> 4 events 0x31; ovf_clr -> overflow=0.
TIMEOUT_CYCLES=16: E0, idle 20 cycles, 1C -> single non-ext make of 1C; bytes AA, FA in IDLE -> no event.
rst_n pulsed low mid F0 sequence with 2 events queued -> ev_valid=0, mods=0 immediately; next byte 1C -> make event.
